// File: rtl/seq_divider_16bits_if.sv
// Handshake bundle for the sequential divider: an operand channel and a result channel.
// The master modport is the side that supplies operands and takes results.
interface seq_divider_16bits_if #(
  parameter int DW = 16
);
  logic            in_valid;
  logic            in_ready;
  logic [2*DW-1:0] dividend;
  logic [DW-1:0]   divisor;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   quotient;
  logic [DW-1:0]   remainder;
  logic            div_by_zero;
  logic            overflow;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/seq_divider_16bits.sv
// Iterative restoring divider: 2*DW-bit dividend / DW-bit divisor, one quotient bit per clock.
// Optional SEQ_DIV_ZERO_SKIP_EN: a zero dividend finishes at the accept edge instead of iterating.
module seq_divider_16bits #(
  parameter int DW = 16
) (
  input  logic                clk,
  input  logic                rst,
  seq_divider_16bits_if.slave bus
);

  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  // Classification of an operand pair at the accept edge.
  typedef enum logic [1:0] {ACC_CALC, ACC_DBZ, ACC_OVF, ACC_ZERO} acc_t;

  state_t          state, state_d;
  acc_t            acc_kind;

  logic [DW:0]     r_q;
  logic [DW-1:0]   q_q;
  logic [DW-1:0]   d_q;
  logic [CW-1:0]   cnt_q;
  logic [DW-1:0]   quo_q;
  logic [DW-1:0]   rem_q;
  logic            dbz_q;
  logic            ovf_q;

  logic [DW-1:0]   div_hi;
  logic [DW-1:0]   div_lo;
  logic            accept;
  logic [DW:0]     t;
  logic [DW:0]     d_ext;
  logic            t_ge_d;
  logic [DW:0]     r_step;
  logic [DW-1:0]   q_step;
  logic            last_step;

  // R < divisor always holds, so the top bit of R is structurally zero.
  logic            unused_r_msb;
  assign unused_r_msb = r_q[DW];

  assign div_hi = bus.dividend[2*DW-1:DW];
  assign div_lo = bus.dividend[DW-1:0];
  assign accept = (state == IDLE) && bus.in_valid;

  // Operand classification; a zero divisor outranks everything else.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    acc_kind = ACC_CALC;
    if (bus.divisor == '0)
      acc_kind = ACC_DBZ;
    else if (div_hi >= bus.divisor)
      acc_kind = ACC_OVF;
`ifdef SEQ_DIV_ZERO_SKIP_EN
    else if (bus.dividend == '0)
      acc_kind = ACC_ZERO;
`else
    else
      acc_kind = ACC_CALC;
`endif
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    t         = {r_q[DW-1:0], q_q[DW-1]};
    d_ext     = {1'b0, d_q};
    t_ge_d    = (t >= d_ext);
    r_step    = t_ge_d ? (t - d_ext) : t;
    q_step    = {q_q[DW-2:0], t_ge_d};
    last_step = (cnt_q == CW'(DW - 1));
  end

  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (accept) state_d = (acc_kind == ACC_CALC) ? CALC : DONE;
      CALC:    if (last_step) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = (state == DONE);
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.overflow    = ovf_q;

  // Datapath; result registers change only when a new result is written.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q   <= '0;
      q_q   <= '0;
      d_q   <= '0;
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dbz_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            unique case (acc_kind)
              ACC_DBZ: begin
                dbz_q <= 1'b1;
                ovf_q <= 1'b0;
                quo_q <= '1;
                rem_q <= div_lo;
              end
              ACC_OVF: begin
                dbz_q <= 1'b0;
                ovf_q <= 1'b1;
                quo_q <= '1;
                rem_q <= div_lo;
              end
              ACC_ZERO: begin
                dbz_q <= 1'b0;
                ovf_q <= 1'b0;
                quo_q <= '0;
                rem_q <= '0;
              end
              default: begin
                r_q   <= {1'b0, div_hi};
                q_q   <= div_lo;
                d_q   <= bus.divisor;
                cnt_q <= '0;
                dbz_q <= 1'b0;
                ovf_q <= 1'b0;
              end
            endcase
          end
        end
        CALC: begin
          r_q   <= r_step;
          q_q   <= q_step;
          cnt_q <= cnt_q + 1'b1;
          if (last_step) begin
            quo_q <= q_step;
            rem_q <= r_step[DW-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_16bits.sv
// Directed self-checking bench for seq_divider_16bits: normal, zero-divisor, overflow,
// backpressure, zero-dividend and mid-operation reset cases with hand-computed results.
module tb_seq_divider_16bits;

  logic clk = 1'b0;
  logic rst;
  int   n_total = 0;
  int   n_pass  = 0;
  int   lat;
  int   seen;

  seq_divider_16bits_if #(.DW(16)) bus ();

  seq_divider_16bits #(.DW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // After the accept edge: drop in_valid, scramble operands, count edges until out_valid.
  task automatic wait_result(output int edges);
    edges = 0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.dividend = 32'hDEADBEEF;
    bus.divisor  = 16'h0001;
    while (!bus.out_valid && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input logic [31:0] dvd, input logic [15:0] dvs, output int edges);
    @(negedge clk);
    check("in_ready_before_op", bus.in_ready, 1'b1);
    bus.in_valid = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dvs;
    @(posedge clk);
    wait_result(edges);
  endtask

  task automatic consume(input string tag);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_out_valid_after_hs"}, bus.out_valid, 1'b0);
    check({tag, "_in_ready_after_hs"}, bus.in_ready, 1'b1);
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_quotient", bus.quotient, 16'h0000);
    check("rst_remainder", bus.remainder, 16'h0000);
    check("rst_dbz", bus.div_by_zero, 1'b0);
    check("rst_ovf", bus.overflow, 1'b0);
    rst = 1'b0;

    // 1000000 / 1000
    run_op(32'h000F4240, 16'h03E8, lat);
    check("t1_latency", lat, 16);
    check("t1_quotient", bus.quotient, 16'h03E8);
    check("t1_remainder", bus.remainder, 16'h0000);
    check("t1_dbz", bus.div_by_zero, 1'b0);
    check("t1_ovf", bus.overflow, 1'b0);
    consume("t1");

    // 65536 / 3 = 21845 rem 1
    run_op(32'h00010000, 16'h0003, lat);
    check("t2_latency", lat, 16);
    check("t2_quotient", bus.quotient, 16'h5555);
    check("t2_remainder", bus.remainder, 16'h0001);
    check("t2_flags", {bus.div_by_zero, bus.overflow}, 2'b00);
    consume("t2");

    // Divide by zero: result visible straight after the accept edge.
    run_op(32'h12345678, 16'h0000, lat);
    check("t3_latency", lat, 0);
    check("t3_dbz", bus.div_by_zero, 1'b1);
    check("t3_ovf", bus.overflow, 1'b0);
    check("t3_quotient", bus.quotient, 16'hFFFF);
    check("t3_remainder", bus.remainder, 16'h5678);
    consume("t3");

    // Overflow: high half equals the divisor.
    run_op(32'h00050000, 16'h0005, lat);
    check("t4_latency", lat, 0);
    check("t4_ovf", bus.overflow, 1'b1);
    check("t4_dbz", bus.div_by_zero, 1'b0);
    check("t4_quotient", bus.quotient, 16'hFFFF);
    check("t4_remainder", bus.remainder, 16'h0000);
    consume("t4");

    // Largest non-overflowing case: 0xFFFEFFFF = 0xFFFF*0xFFFF + 0xFFFE
    run_op(32'hFFFEFFFF, 16'hFFFF, lat);
    check("t5_latency", lat, 16);
    check("t5_quotient", bus.quotient, 16'hFFFF);
    check("t5_remainder", bus.remainder, 16'hFFFE);
    check("t5_flags", {bus.div_by_zero, bus.overflow}, 2'b00);
    consume("t5");

    // Backpressure, with a second request held pending the whole time.
    bus.out_ready = 1'b0;
    run_op(32'h00010000, 16'h0003, lat);
    check("t6_latency", lat, 16);
    bus.in_valid = 1'b1;
    bus.dividend = 32'h00000064;
    bus.divisor  = 16'h0007;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("t6_hold_out_valid", bus.out_valid, 1'b1);
      check("t6_hold_in_ready", bus.in_ready, 1'b0);
      check("t6_hold_quotient", bus.quotient, 16'h5555);
      check("t6_hold_remainder", bus.remainder, 16'h0001);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t6_out_valid_after_hs", bus.out_valid, 1'b0);
    check("t6_in_ready_after_hs", bus.in_ready, 1'b1);
    @(posedge clk);
    wait_result(lat);
    // 100 / 7 = 14 rem 2
    check("t7_latency", lat, 16);
    check("t7_quotient", bus.quotient, 16'h000E);
    check("t7_remainder", bus.remainder, 16'h0002);
    check("t7_flags", {bus.div_by_zero, bus.overflow}, 2'b00);
    consume("t7");

    // Zero dividend.
    run_op(32'h00000000, 16'h0007, lat);
`ifdef SEQ_DIV_ZERO_SKIP_EN
    check("t8_latency", lat, 0);
`else
    check("t8_latency", lat, 16);
`endif
    check("t8_quotient", bus.quotient, 16'h0000);
    check("t8_remainder", bus.remainder, 16'h0000);
    check("t8_flags", {bus.div_by_zero, bus.overflow}, 2'b00);
    consume("t8");

    // Seed a non-zero result, then reset on CALC step 8 of the next operation.
    run_op(32'h00000064, 16'h0007, lat);
    check("t9_quotient", bus.quotient, 16'h000E);
    consume("t9");
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.dividend = 32'h000F4240;
    bus.divisor  = 16'h03E8;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("t10_out_valid", bus.out_valid, 1'b0);
    check("t10_in_ready", bus.in_ready, 1'b1);
    check("t10_quotient", bus.quotient, 16'h0000);
    check("t10_remainder", bus.remainder, 16'h0000);
    check("t10_flags", {bus.div_by_zero, bus.overflow}, 2'b00);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("t10_no_late_result", seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
